// File: rtl/branch_comp_seq_if.sv
// Request/result handshake bundle for the sequential branch comparator.
// The master drives requests and result acceptance; the slave is the comparator.
interface branch_comp_seq_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data_in_A;
  logic [DATA_W-1:0] data_in_B;
  logic [2:0]        funct3;
  logic [TAG_W-1:0]  tag_in;
  logic              out_valid;
  logic              out_ready;
  logic              br_eq;
  logic              br_lt;
  logic              taken;
  logic              illegal;
  logic [TAG_W-1:0]  tag_out;

  modport master (
    output in_valid, data_in_A, data_in_B, funct3, tag_in, out_ready,
    input  in_ready, out_valid, br_eq, br_lt, taken, illegal, tag_out
  );

  modport slave (
    input  in_valid, data_in_A, data_in_B, funct3, tag_in, out_ready,
    output in_ready, out_valid, br_eq, br_lt, taken, illegal, tag_out
  );
endinterface

// File: rtl/branch_comp_seq.sv
// Multi-cycle RISC-V branch comparator: walks the operands MSB-first one
// CHUNK_W slice per cycle and reports eq/lt/taken with a pass-through tag.
module branch_comp_seq #(
  parameter int DATA_W     = 32,
  parameter int CHUNK_W    = 8,
  parameter int EARLY_EXIT = 0,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  branch_comp_seq_if.slave bus
);
  localparam int NCHUNK = DATA_W / CHUNK_W;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t            state_reg;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [2:0]        f3_reg;
  logic [TAG_W-1:0]  tag_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic              decided_reg;
  logic              eq_acc_reg;
  logic              lt_acc_reg;
  logic              in_ready_reg;
  logic              out_valid_reg;
  logic              br_eq_reg;
  logic              br_lt_reg;
  logic              taken_reg;
  logic              illegal_reg;
  logic [TAG_W-1:0]  tag_out_reg;

  logic [CHUNK_W-1:0] a_slice [NCHUNK];
  logic [CHUNK_W-1:0] b_slice [NCHUNK];

  genvar gi;
  generate
    for (gi = 0; gi < NCHUNK; gi++) begin : g_slice
      assign a_slice[gi] = a_reg[gi*CHUNK_W +: CHUNK_W];
      assign b_slice[gi] = b_reg[gi*CHUNK_W +: CHUNK_W];
    end
  endgenerate

  logic [CHUNK_W-1:0] sa;
  logic [CHUNK_W-1:0] sb;
  logic slice_diff;
  logic slice_lt;
  logic eq_next;
  logic lt_next;
  logic last_step;
  logic taken_next;
  logic illegal_next;

  always_comb begin
    sa         = a_slice[idx_reg];
    sb         = b_slice[idx_reg];
    slice_diff = (sa != sb);
    // Only the slice holding the sign bit is compared signed, and only for BLT/BGE.
    if ((idx_reg == TOP_IDX) && !f3_reg[1]) begin
      slice_lt = $signed(sa) < $signed(sb);
    end else begin
      slice_lt = sa < sb;
    end
    eq_next      = decided_reg ? eq_acc_reg : !slice_diff;
    lt_next      = decided_reg ? lt_acc_reg : (slice_diff && slice_lt);
    last_step    = (idx_reg == '0) || ((EARLY_EXIT != 0) && slice_diff);
    taken_next   = 1'b0;
    illegal_next = 1'b0;
    case (f3_reg)
      3'b000:         taken_next = eq_next;
      3'b001:         taken_next = !eq_next;
      3'b100, 3'b110: taken_next = lt_next;
      3'b101, 3'b111: taken_next = !lt_next;
      default:        illegal_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      f3_reg        <= '0;
      tag_reg       <= '0;
      idx_reg       <= '0;
      decided_reg   <= 1'b0;
      eq_acc_reg    <= 1'b1;
      lt_acc_reg    <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      br_eq_reg     <= 1'b0;
      br_lt_reg     <= 1'b0;
      taken_reg     <= 1'b0;
      illegal_reg   <= 1'b0;
      tag_out_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg        <= bus.data_in_A;
            b_reg        <= bus.data_in_B;
            f3_reg       <= bus.funct3;
            tag_reg      <= bus.tag_in;
            idx_reg      <= TOP_IDX;
            decided_reg  <= 1'b0;
            eq_acc_reg   <= 1'b1;
            lt_acc_reg   <= 1'b0;
            in_ready_reg <= 1'b0;
            state_reg    <= CMP;
          end
        end
        CMP: begin
          eq_acc_reg  <= eq_next;
          lt_acc_reg  <= lt_next;
          decided_reg <= decided_reg | slice_diff;
          if (last_step) begin
            out_valid_reg <= 1'b1;
            br_eq_reg     <= eq_next;
            br_lt_reg     <= lt_next;
            taken_reg     <= taken_next;
            illegal_reg   <= illegal_next;
            tag_out_reg   <= tag_reg;
            state_reg     <= DONE;
          end else begin
            idx_reg <= idx_reg - 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.br_eq     = br_eq_reg;
  assign bus.br_lt     = br_lt_reg;
  assign bus.taken     = taken_reg;
  assign bus.illegal   = illegal_reg;
  assign bus.tag_out   = tag_out_reg;
endmodule

// File: doc/branch_comp_seq.md
Name: branch_comp_seq

Overview:
Parametrised, multi-cycle successor to the single-cycle branch comparator. Accepts two DATA_W-bit operands and a RISC-V branch funct3, compares them MSB-first in CHUNK_W-bit slices (one slice per cycle), and returns eq/lt flags plus a resolved taken bit. A valid/ready handshake on both sides lets it sit between decode/execute and the PC-redirect logic. A tag is carried through so that results can be matched to the issuing instruction.

Parameters:
DATA_W, 32, operand width in bits; must be a multiple of CHUNK_W.
CHUNK_W, 8, bits compared per cycle; NCHUNK = DATA_W/CHUNK_W, with NCHUNK >= 1.
EARLY_EXIT, 0, when 1, go to DONE on the first differing slice; when 0, latency is always NCHUNK.
TAG_W, 4, width of the pass-through tag.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
in_valid  in  1  request valid.
in_ready  out  1  block can accept a request.
data_in_A  in  DATA_W  operand A (rs1).
data_in_B  in  DATA_W  operand B (rs2).
funct3  in  3  000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
tag_in  in  TAG_W  request tag.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
br_eq  out  1  A == B.
br_lt  out  1  A < B, signed or unsigned according to funct3[1].
taken  out  1  resolved branch decision.
illegal  out  1  funct3 was 010 or 011.
tag_out  out  TAG_W  tag of the current result.

Behaviour:
- Reset, asynchronous: state=IDLE; in_ready=1; out_valid, br_eq, br_lt, taken, illegal=0; tag_out=0; operand/funct3/tag registers=0. Reset mid-operation aborts the in-flight request and produces no result.
- States:
  - IDLE: in_ready=1. On in_valid: latch A, B, funct3, tag; idx=NCHUNK-1; decided=0; eq_acc=1; lt_acc=0; go to CMP.
  - CMP: in_ready=0. Each cycle compares slice idx.
    - Top slice (idx=NCHUNK-1) with funct3[1]=0: signed compare of the slice.
    - All other slices, and every slice when funct3[1]=1: unsigned compare.
    - Only while decided=0: if the slices differ, set eq_acc=0, set lt_acc = sliceA<sliceB, set decided=1.
    - Advance: if idx==0, or (EARLY_EXIT and the slice differs), go to DONE; otherwise idx=idx-1.
  - DONE: out_valid=1.
    - br_eq=eq_acc; br_lt=lt_acc.
    - taken: BEQ=eq, BNE=!eq, BLT/BLTU=lt, BGE/BGEU=!lt. For illegal funct3: taken=0, illegal=1.
    - On out_ready: out_valid=0; go to IDLE.
- Latency: request accepted at edge t; out_valid rises after edge t+NCHUNK (EARLY_EXIT=0). With EARLY_EXIT=1, it rises after edge t+k, where k = 1 + number of equal leading slices, k <= NCHUNK.
- Outputs are registered and held stable while out_valid=1 && out_ready=0. Outside DONE, br_eq/br_lt/taken/illegal hold their last values and are don't-care; the bench checks them only when out_valid=1.
- No overlap: in_ready=0 from CMP entry until the DONE handshake. in_ready returns to 1 the cycle after the out handshake, so back-to-back throughput is one result per NCHUNK+2 cycles.
- Operands are sampled only at acceptance. Input changes during CMP/DONE have no effect.
- NCHUNK=1 degenerates to a single CMP cycle using a full-width signed/unsigned compare.
- in_valid held with no acceptance carries no obligation; requests are never dropped.

Test Plan:
- DATA_W=32, CHUNK_W=8, EARLY_EXIT=0; A=0xFFFFFFFF, B=0x00000001, funct3=100 (BLT) -> out_valid after exactly 4 cycles; br_lt=1, br_eq=0, taken=1. Same operands, funct3=110 (BLTU) -> br_lt=0, taken=0.
- A=B=0x12345678, funct3=000 -> br_eq=1, taken=1; funct3=001 -> taken=0; funct3=011 -> illegal=1, taken=0.
- EARLY_EXIT=1; A=0x80000000, B=0x7FFFFFFF, BGE -> out_valid after 1 cycle, br_lt=1, taken=0. A=0x00000100, B=0x00000101 -> 4 cycles, br_lt=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs and tag_out stable, in_ready=0. Assert out_ready -> in_ready=1 on the next cycle. Present a new request and check tag_out=0x3 on its result.
- Assert reset while in CMP at idx=2 -> out_valid=0 and in_ready=1 immediately. The next request completes normally in NCHUNK cycles.
- Random A/B/funct3 over 10k requests with random out_ready stalls -> br_eq/br_lt/taken match a single-cycle reference model; no lost or duplicated results.
